// File: rtl/pipectrl.sv
// Pipeline sequencer for the 5-stage semiMIPS core: stage enables, flushes, PC select.
// Define PIPECTRL_PERF_EN to add the stallcnt/flushcnt performance counters.
module pipectrl #(
  parameter int AWIDTH     = 32,
  parameter int MEMTIMEOUT = 16,
  parameter int CWIDTH     = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              idexmemrd,
  input  logic [4:0]        idexrt,
  input  logic [4:0]        ifidrs,
  input  logic [4:0]        ifidrt,
  input  logic              bbne,
  input  logic              bbeq,
  input  logic              bblez,
  input  logic              bbgtz,
  input  logic              jump,
  input  logic              zero,
  input  logic              negative,
  input  logic [AWIDTH-1:0] branaddr,
  input  logic [AWIDTH-1:0] jmpaddr,
  input  logic              memrd,
  input  logic              memwr,
  input  logic              memack,
  input  logic              finin,
  output logic              pcwe,
  output logic              ifidwe,
  output logic              idexwe,
  output logic              exmemwe,
  output logic              memwbwe,
  output logic              ifidflush,
  output logic              idexflush,
  output logic              exmemflush,
  output logic [1:0]        pcsel,
  output logic [AWIDTH-1:0] pctarget,
  output logic              halted,
  output logic              memerr
`ifdef PIPECTRL_PERF_EN
  ,
  output logic [CWIDTH-1:0] stallcnt,
  output logic [CWIDTH-1:0] flushcnt
`endif
);

  localparam int WCW = $clog2(MEMTIMEOUT + 1);

  if (MEMTIMEOUT < 2) begin : g_badTimeout
    $error("pipectrl: MEMTIMEOUT must be at least 2");
  end
  if (CWIDTH < 1) begin : g_badCwidth
    $error("pipectrl: CWIDTH must be at least 1");
  end

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_HALT} state_e;

  state_e         state_q, state_d;
  logic [WCW-1:0] waitCnt_q, waitCnt_d;
  logic           memErr_q, memErr_d;

  logic       taken, memWait, loadUse, redirect;
  logic [4:0] weVec;
  logic [2:0] flushVec;

  assign taken = (bbeq & zero) | (bbne & ~zero) | (bblez & (zero | negative))
               | (bbgtz & ~zero & ~negative);
  assign memWait = (memrd | memwr) & ~memack;
  assign loadUse = idexmemrd & (idexrt != 5'd0) & ((idexrt == ifidrs) | (idexrt == ifidrt));

  assign {pcwe, ifidwe, idexwe, exmemwe, memwbwe} = weVec;
  assign {ifidflush, idexflush, exmemflush}       = flushVec;
  assign memerr = memErr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_RUN;
      waitCnt_q <= '0;
      memErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      memErr_q  <= memErr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    memErr_d  = memErr_q;
    weVec     = 5'b00000;
    flushVec  = 3'b000;
    pcsel     = 2'd0;
    pctarget  = '0;
    halted    = 1'b0;
    redirect  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (finin) begin
          state_d = ST_HALT;
        end else if (memWait) begin
          state_d   = ST_WAIT;
          waitCnt_d = WCW'(1);
        end else if (jump | taken) begin
          redirect = 1'b1;
          weVec    = 5'b11111;
          flushVec = 3'b111;
          pcsel    = jump ? 2'd2 : 2'd1;
          pctarget = jump ? jmpaddr : branaddr;
        end else if (loadUse) begin
          weVec    = 5'b00111;
          flushVec = 3'b010;
        end else begin
          weVec = 5'b11111;
        end
      end
      ST_WAIT: begin
        if (!memack) begin
          waitCnt_d = waitCnt_q + 1'b1;
          if (waitCnt_q == WCW'(MEMTIMEOUT - 1)) begin
            state_d  = ST_HALT;
            memErr_d = 1'b1;
          end
        end else begin
          state_d   = ST_RUN;
          waitCnt_d = '0;
          if (loadUse) begin
            weVec    = 5'b00111;
            flushVec = 3'b010;
          end else begin
            weVec = 5'b11111;
          end
        end
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_RUN;
    endcase
    // Reset holds every stage in bubble-load mode regardless of state.
    if (!rstn) begin
      weVec    = 5'b00000;
      flushVec = 3'b111;
      pcsel    = 2'd0;
      pctarget = '0;
      halted   = 1'b0;
      redirect = 1'b0;
    end
  end

`ifdef PIPECTRL_PERF_EN
  logic [CWIDTH-1:0] stallCnt_q, flushCnt_q;

  assign stallcnt = stallCnt_q;
  assign flushcnt = flushCnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if ((state_q != ST_HALT) && !pcwe && (stallCnt_q != {CWIDTH{1'b1}}))
        stallCnt_q <= stallCnt_q + 1'b1;
      if (redirect && (flushCnt_q != {CWIDTH{1'b1}}))
        flushCnt_q <= flushCnt_q + 1'b1;
    end
  end
`endif

endmodule

// File: doc/pipectrl.md
Name: pipectrl

Overview:
- Central pipeline sequencer for the 5-stage semiMIPS core.
- Drives per-stage write enables and flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves branches/jumps from EX/MEM outputs (bbne/bbeq/bblez/bbgtz/jump with zero/negative flags) and selects the next PC.
- Inserts load-use bubbles, freezes the pipe on data-memory wait, and parks the core when fin reaches MEM/WB.

Parameters:
AWIDTH, 32, PC/branch/jump address width
MEMTIMEOUT, 16, max consecutive data-memory wait cycles before error (>=2)
CWIDTH, 16, width of performance counters (optional feature)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
idexmemrd  in  1  ID/EX instruction is a load
idexrt  in  5  ID/EX destination rt of the load
ifidrs  in  5  IF/ID source rs
ifidrt  in  5  IF/ID source rt
bbne, bbeq, bblez, bbgtz, jump  in  1 each  EX/MEM branch/jump controls
zero, negative  in  1 each  EX/MEM ALU flags
branaddr  in  AWIDTH  EX/MEM branch target
jmpaddr  in  AWIDTH  EX/MEM jump target
memrd, memwr  in  1 each  EX/MEM memory request
memack  in  1  data memory done, sampled same cycle
finin  in  1  MEM/WB fin flag
pcwe, ifidwe, idexwe, exmemwe, memwbwe  out  1 each  stage write enables
ifidflush, idexflush, exmemflush  out  1 each  load a bubble (all controls 0) at next edge
pcsel  out  2  0=PC+4, 1=branch target, 2=jump target
pctarget  out  AWIDTH  selected redirect target; 0 when pcsel=0
halted  out  1  core parked
memerr  out  1  sticky memory timeout

Behaviour:
- State register: RUN, WAIT, HALT. Reset (rstn=0, async) -> RUN, waitcnt=0, memerr=0.
- While rstn=0: all *we=0, all *flush=1, pcsel=0, pctarget=0, halted=0, memerr=0.
- Outputs are combinational from state + current inputs. Transitions are registered on posedge clk.
- taken = bbeq&zero | bbne&~zero | bblez&(zero|negative) | bbgtz&~zero&~negative. jump has priority over taken.
- memwait = (memrd|memwr) & ~memack.
- loaduse = idexmemrd & idexrt!=0 & (idexrt==ifidrs | idexrt==ifidrt).
- Priority in RUN, highest first: finin > memwait > jump/taken > loaduse > normal.
- RUN, finin=1:
  - All we=0; next state HALT.
  - A branch/stall in the same cycle is ignored.
- RUN, memwait:
  - All we=0, no flush; next state WAIT, waitcnt=1.
- RUN, jump:
  - pcsel=2, pctarget=jmpaddr.
  - ifidflush=idexflush=exmemflush=1; all we=1.
  - Three-instruction squash; redirect latency 1 cycle.
- RUN, taken: same as jump with pcsel=1, pctarget=branaddr.
- RUN, loaduse:
  - pcwe=ifidwe=0, idexflush=1; other we=1.
  - Exactly one bubble; the next cycle re-evaluates.
- RUN, normal: all we=1, no flush, pcsel=0.
- WAIT:
  - memack=0: all we=0; waitcnt++.
  - waitcnt reaching MEMTIMEOUT -> HALT and memerr<=1.
  - memack=1: all we=1, no flush; next state RUN, waitcnt=0.
  - Branch flags are ignored in WAIT; branch and memory ops are mutually exclusive in the ISA.
  - Load-use is evaluated on the release cycle as in RUN.
- HALT:
  - All we=0, flushes 0, halted=1.
  - Exits only on reset. memerr holds.
- Reset mid-WAIT or mid-HALT aborts immediately to RUN; no pending redirect survives.
- Widths: waitcnt is ceil(log2(MEMTIMEOUT+1)) bits; it never wraps (saturates at the HALT transition).

Optional Feature:
- Macro PIPECTRL_PERF_EN. When defined, add the following outputs:
  - stallcnt [CWIDTH-1:0]: counts cycles with pcwe=0 in RUN/WAIT.
  - flushcnt [CWIDTH-1:0]: counts redirects.
- Both counters saturate at all-ones, reset to 0, and freeze in HALT.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Load-use: idexmemrd=1, idexrt=5, ifidrs=5 for one cycle -> pcwe=ifidwe=0, idexflush=1 that cycle; normal next cycle. With idexrt=0 -> no stall.
- Branch: bbeq=1, zero=1, branaddr=0x40 -> pcsel=1, pctarget=0x40, three flushes=1. With bbgtz=1, negative=1 -> no redirect. Setting jump=1 together with bbeq=1, zero=1, jmpaddr=0x80 -> pcsel=2, pctarget=0x80.
- Memory wait: memrd=1, memack=0 for 3 cycles then 1 -> we=0 for 3 cycles, all 1 on the ack cycle, state back to RUN.
- Timeout: memwr=1, memack held 0 with MEMTIMEOUT=16 -> memerr=1, halted=1 after 16 stalled cycles; both stay set until rstn=0.
- Halt: finin=1 while taken=1 and loaduse=1 -> no redirect or flush, all we=0, halted=1 next cycle; rstn pulse low -> all we=0, flushes=1 during reset, then RUN.
- PERF (PIPECTRL_PERF_EN): 2 load-use stalls + 1 branch -> stallcnt=2, flushcnt=1.
